// File: rtl/ir_queue_pkg.sv
// ir_pkg: shared constants and width helper for the ir_queue slice.
// Default geometry, count width function and the empty-output word.
package ir_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 4;

  localparam logic [WIDTH_DEF-1:0] EMPTY_WORD = '0;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ir_queue_if.sv
// ir_queue_if: fetch/stepper-facing bundle of the instruction queue.
// master = fetch + stepper side, slave = the queue itself.
interface ir_queue_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  import ir_pkg::*;

  localparam int CW = cnt_w(DEPTH);

  logic             s;
  logic [WIDTH-1:0] i_in;
  logic             adv;
  logic             flush;
  logic [WIDTH-1:0] i_out;
  logic             i_valid;
  logic             full;
  logic [CW-1:0]    count;
  logic             ovf;

  modport master (
    output s, i_in, adv, flush,
    input  i_out, i_valid, full, count, ovf
  );

  modport slave (
    input  s, i_in, adv, flush,
    output i_out, i_valid, full, count, ovf
  );

endinterface

// File: rtl/ir_queue_slot_ram.sv
// ir_slot_ram: DEPTH x WIDTH word store for ir_queue.
// One synchronous write port, one asynchronous read port, no reset.
module ir_slot_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ir_queue.sv
// ir_queue: instruction register with a small circular prefetch queue.
// Optional same-cycle bypass when empty: define IR_QUEUE_BYPASS_EN.
module ir_queue
  import ir_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input logic        clk,
  input logic        rst_n,
  ir_queue_if.slave  q
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    cnt;
  logic             ovf_q;
  logic             empty, full_w;
  logic             pop, push, byp;
  logic             we;
  logic [PW-1:0]    waddr;
  logic [WIDTH-1:0] rdata;

  assign empty  = (cnt == '0);
  assign full_w = (cnt == CW'(DEPTH));

`ifdef IR_QUEUE_BYPASS_EN
  assign byp = empty & q.s & q.adv & ~q.flush;
`else
  assign byp = 1'b0;
`endif

  assign pop  = q.adv & ~empty & ~q.flush;
  assign push = q.s & (~full_w | pop) & ~byp;

  // A flush restarts the ring at slot 0 so a same-cycle
  // branch-target word becomes the sole entry.
  assign we    = q.flush ? q.s : push;
  assign waddr = q.flush ? '0 : wr_ptr;

  ir_slot_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (q.i_in),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
    end else if (q.flush) begin
      rd_ptr <= '0;
      wr_ptr <= q.s ? PW'(1) : '0;
      cnt    <= q.s ? CW'(1) : '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case (1'b1)
        push & ~pop: cnt <= cnt + CW'(1);
        pop & ~push: cnt <= cnt - CW'(1);
        default:     cnt <= cnt;
      endcase
      if (q.s & full_w & ~pop) ovf_q <= 1'b1;
    end
  end

`ifdef IR_QUEUE_BYPASS_EN
  assign q.i_valid = ~empty | q.s;
  assign q.i_out   = !empty ? rdata :
                     q.s    ? q.i_in : WIDTH'(EMPTY_WORD);
`else
  assign q.i_valid = ~empty;
  assign q.i_out   = empty ? WIDTH'(EMPTY_WORD) : rdata;
`endif

  assign q.full  = full_w;
  assign q.count = cnt;
  assign q.ovf   = ovf_q;

endmodule

// File: tb/tb_ir_queue.sv
// tb_ir_queue: directed self-checking bench for ir_queue (WIDTH=8, DEPTH=4).
// Bypass expectations follow IR_QUEUE_BYPASS_EN when defined.
module tb_ir_queue;

  localparam int W = 8;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nchk = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  ir_queue_if #(.WIDTH(W), .DEPTH(D)) bus ();

  ir_queue #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (bus)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.s = 1'b0;
    bus.adv = 1'b0;
    bus.flush = 1'b0;
  endtask

  task automatic push(input logic [7:0] w);
    bus.s = 1'b1;
    bus.i_in = w;
    tick();
    idle();
  endtask

  task automatic pop();
    bus.adv = 1'b1;
    tick();
    idle();
  endtask

  task automatic zero_out(input string tag);
    chk({tag, "_iout"}, 32'(bus.i_out), 32'h0);
    chk({tag, "_vld"}, 32'(bus.i_valid), 32'h0);
    chk({tag, "_full"}, 32'(bus.full), 32'h0);
    chk({tag, "_cnt"}, 32'(bus.count), 32'h0);
    chk({tag, "_ovf"}, 32'(bus.ovf), 32'h0);
  endtask

  logic [7:0] exp_q [4];

  initial begin
    idle();
    bus.i_in = 8'h00;
    #1;
    zero_out("rst");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // basic push / pop
    push(8'hAA);
    tick();
    push(8'h55);
    chk("t1_head", 32'(bus.i_out), 32'hAA);
    chk("t1_cnt", 32'(bus.count), 32'd2);
    pop();
    chk("t1_pop_head", 32'(bus.i_out), 32'h55);
    chk("t1_pop_cnt", 32'(bus.count), 32'd1);
    pop();
    chk("t1_empty_vld", 32'(bus.i_valid), 32'h0);
    chk("t1_empty_iout", 32'(bus.i_out), 32'h0);

    // fill and overflow
    for (int k = 1; k <= 4; k++) push(8'(k));
    chk("t2_full", 32'(bus.full), 32'h1);
    chk("t2_ovf0", 32'(bus.ovf), 32'h0);
    push(8'h05);
    chk("t2_ovf1", 32'(bus.ovf), 32'h1);
    chk("t2_full1", 32'(bus.full), 32'h1);
    chk("t2_cnt", 32'(bus.count), 32'd4);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("t2_pop%0d", k), 32'(bus.i_out), 32'(k));
      pop();
    end
    chk("t2_end_vld", 32'(bus.i_valid), 32'h0);
    chk("t2_end_iout", 32'(bus.i_out), 32'h0);
    chk("t2_ovf_hold", 32'(bus.ovf), 32'h1);

    // push+pop while full, then wrap
    for (int k = 1; k <= 4; k++) push(8'(k));
    bus.s = 1'b1;
    bus.i_in = 8'hEE;
    bus.adv = 1'b1;
    tick();
    idle();
    chk("t3_cnt", 32'(bus.count), 32'd4);
    chk("t3_head", 32'(bus.i_out), 32'h02);
    exp_q = '{8'h02, 8'h03, 8'h04, 8'hEE};
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t3_pop%0d", k), 32'(bus.i_out), 32'(exp_q[k]));
      pop();
    end
    chk("t3_empty", 32'(bus.i_valid), 32'h0);
    push(8'h10);
    for (int k = 0; k < 10; k++) begin
      bus.s = 1'b1;
      bus.i_in = 8'(8'h11 + k);
      bus.adv = 1'b1;
      tick();
      idle();
      chk($sformatf("t3_wrap%0d", k), 32'(bus.i_out), 32'(8'h11 + k));
      chk($sformatf("t3_wcnt%0d", k), 32'(bus.count), 32'd1);
    end
    pop();
    chk("t3_drain", 32'(bus.count), 32'd0);

    // flush with same-cycle fetch (adv ignored)
    push(8'hA1);
    push(8'hA2);
    push(8'hA3);
    chk("t4_cnt3", 32'(bus.count), 32'd3);
    bus.flush = 1'b1;
    bus.s = 1'b1;
    bus.adv = 1'b1;
    bus.i_in = 8'h7C;
    tick();
    idle();
    chk("t4_cnt", 32'(bus.count), 32'd1);
    chk("t4_head", 32'(bus.i_out), 32'h7C);
    chk("t4_ovf", 32'(bus.ovf), 32'h0);
    chk("t4_vld", 32'(bus.i_valid), 32'h1);

    // asynchronous reset between edges
    push(8'h7D);
    chk("t5_cnt2", 32'(bus.count), 32'd2);
    #3 rst_n = 1'b0;
    #1;
    zero_out("t5_arst");
    #1 rst_n = 1'b1;
    pop();
    zero_out("t5_adv_empty");

    // empty queue, push and consume together
    bus.s = 1'b1;
    bus.adv = 1'b1;
    bus.i_in = 8'h3A;
    #1;
`ifdef IR_QUEUE_BYPASS_EN
    chk("t6_byp_iout", 32'(bus.i_out), 32'h3A);
    chk("t6_byp_vld", 32'(bus.i_valid), 32'h1);
    tick();
    idle();
    chk("t6_byp_cnt", 32'(bus.count), 32'd0);
`else
    chk("t6_nb_iout", 32'(bus.i_out), 32'h0);
    chk("t6_nb_vld", 32'(bus.i_valid), 32'h0);
    tick();
    idle();
    chk("t6_nb_cnt", 32'(bus.count), 32'd1);
    chk("t6_nb_head", 32'(bus.i_out), 32'h3A);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/ir_queue.md
# ir_queue

Parametrised instruction register with a small prefetch queue, successor to the single-word 8-bit IR of the 7-step processor. Fetch logic pushes instruction words with the load strobe `s`; the control stepper consumes them from the head with `adv`. Branches discard prefetched words with `flush`. The block sits between the RAM data bus and the stepper/decoder, so the stepper never waits on a fetch when the queue is non-empty.

## Interface
Parameters:
- WIDTH, 8, instruction word width in bits (≥ 4).
- DEPTH, 4, queue entries; power of two, ≥ 2.

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s  in  1  load strobe; `i_in` is written at the tail on the clock edge when `s`=1.
- i_in  in  WIDTH  instruction word from the bus.
- adv  in  1  consume the head word; effective only when `i_valid`=1.
- flush  in  1  discard all queued words (taken branch).
- i_out  out  WIDTH  head word; 0 when the queue is empty.
- i_valid  out  1  queue is non-empty (head presented on `i_out`).
- full  out  1  count == DEPTH.
- count  out  $clog2(DEPTH)+1  number of stored words.
- ovf  out  1  sticky overflow flag.

## Operation
- Storage is a circular array with rd_ptr and wr_ptr, each $clog2(DEPTH) bits. Both pointers wrap modulo DEPTH. `count` is a separate register.
- Push: `s`=1 and (not full, or `adv` in the same cycle). The word is written at wr_ptr, and wr_ptr increments.
- Pop: `adv`=1 and `i_valid`=1. rd_ptr increments.
- Push and pop in the same cycle:
  - `count` is unchanged.
  - This is legal when full: the head leaves and the new word takes the tail.
- `s`=1 while full with no pop:
  - The word is dropped.
  - The queue contents are unchanged.
  - `ovf` is set.
- `adv` while empty is ignored. No state changes and no error is flagged.
- `flush`:
  - It has priority over `adv`.
  - Pointers and count return to 0, and `ovf` is cleared.
  - If `s`=1 in the same cycle, `i_in` is stored as the sole entry and count becomes 1. This lets the branch-target fetch overlap the flush.
- Outputs are decoded combinationally from registered state: `i_out`, `i_valid`, `full`, and `count`.
- Reset (asynchronous, any time, including mid-push):
  - Pointers, `count` and `ovf` go to 0, so `i_out`=0, `i_valid`=0 and `full`=0.
  - The storage array need not be cleared.

## Timing
- Push to visible: a word pushed at edge N appears on `i_out` after edge N, provided it is the head. Latency is 1 cycle.
- Pop: the next word (or 0) is presented after the edge at which `adv` is sampled.
- Throughput: one push and one pop per cycle, sustained.
- `ovf` rises on the edge after the dropped push. It then holds until `flush` or reset.
- Reset release: the first push is accepted on the first rising edge with `rst_n`=1.

## Configuration
- Macro: `IR_QUEUE_BYPASS_EN`.
- Defined, when the queue is empty and `s`=1:
  - `i_in` drives `i_out` combinationally and `i_valid`=1 in the same cycle.
  - If `adv`=1 in that cycle, the word is consumed without being stored, and count stays 0.
  - If `adv`=0, the word is stored normally.
- Undefined:
  - There is no combinational path from `i_in` to `i_out`.
  - An empty queue always gives 1-cycle latency.
  - `adv` while empty is ignored, even if `s`=1 in the same cycle.

## Structure
- Package `ir_pkg` holds:
  - the default WIDTH/DEPTH constants;
  - a `ptr_t`/`cnt_t` width helper (function returning $clog2(DEPTH)+1);
  - the all-zero empty-output constant.
- Sub-module `ir_slot_ram` holds the storage: DEPTH×WIDTH registers, one write port, one asynchronous read port, no reset.
- `ir_queue` holds the pointer, count, flag and bypass logic.

## Test plan
- Reset, then push 8'hAA and later 8'h55 with `adv`=0 → `i_out`=8'hAA, count=2. Pulse `adv` → `i_out`=8'h55, count=1.
- Push 8'h01..8'h04 (DEPTH=4), then push 8'h05 → full=1, ovf=1, and pops return 01,02,03,04 in order, then `i_valid`=0 and `i_out`=0.
- With full=1, `s`=1 (8'hEE) and `adv`=1 in the same cycle → count stays 4, head advances, and 8'hEE is popped last. Run 10 further push/pop cycles to confirm pointer wrap.
- With 3 words queued, assert `flush` and `s` (8'h7C) together → count=1, `i_out`=8'h7C, ovf=0.
- Assert `rst_n`=0 asynchronously between edges while count=2 → all outputs 0 immediately. Pulse `adv` while empty → no change.
- With `IR_QUEUE_BYPASS_EN`, empty queue, `s`=1 (8'h3A) and `adv`=1 → `i_out`=8'h3A in the same cycle and count remains 0. Without the macro → count=1 after the edge.
